// File: rtl/counter_scheduler_if.sv
// Request/grant bundle between requesters and the shared interval counter.
// master: requester side (drives req/duration); slave: the scheduler.
interface counter_scheduler_if #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned NUM_BITS = 4
) ();
    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ*NUM_BITS-1:0] duration;
    logic [NUM_REQ-1:0]          grant;
    logic                        busy;
    logic [NUM_BITS-1:0]         count_out;
    logic [NUM_REQ-1:0]          done;
    logic                        aborted;

    modport master (
        output req, duration,
        input  grant, busy, count_out, done, aborted
    );

    modport slave (
        input  req, duration,
        output grant, busy, count_out, done, aborted
    );
endinterface

// File: rtl/counter_scheduler.sv
// Round-robin scheduler sharing one interval counter among NUM_REQ requesters.
// Optional feature: define SCHED_ABORT_EN to abandon an interval when the
// winner drops its request during counting (pulses aborted, no done).
module counter_scheduler #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned NUM_BITS = 4
) (
    input logic                clk,
    input logic                n_rst,
    counter_scheduler_if.slave bus
);
    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_BITS-1:0] CountOne = NUM_BITS'(1);

    typedef enum logic [1:0] {StIdle, StCount, StDone} state_t;

    state_t              state_q;
    logic [PTR_W-1:0]    ptr_q;
    logic [NUM_BITS-1:0] limit_q;
    logic [NUM_BITS-1:0] count_q;
    logic [NUM_REQ-1:0]  grant_q;
    logic [NUM_REQ-1:0]  done_q;
    logic                busy_q;
    logic                aborted_q;

    logic [NUM_BITS-1:0] dur [NUM_REQ];
    logic                any_req;
    logic [PTR_W-1:0]    winner;
    logic [NUM_REQ-1:0]  win_onehot;
    logic [NUM_BITS-1:0] win_limit;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_dur
        assign dur[k] = bus.duration[k*NUM_BITS +: NUM_BITS];
    end

    // Round-robin search starting just after the last winner, wrapping.
    always_comb begin
        int unsigned cand;
        any_req = 1'b0;
        winner  = ptr_q;
        cand    = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!any_req && bus.req[PTR_W'(cand)]) begin
                any_req = 1'b1;
                winner  = PTR_W'(cand);
            end
        end
    end

    // Winner's one-hot grant and rollover value; a zero duration counts as one.
    always_comb begin
        win_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
        win_limit  = (dur[winner] == '0) ? CountOne : dur[winner];
    end

    // Scheduler FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q   <= StIdle;
            ptr_q     <= PTR_W'(NUM_REQ - 1);
            limit_q   <= '0;
            count_q   <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            busy_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            done_q    <= '0;
            aborted_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (any_req) begin
                        state_q <= StCount;
                        grant_q <= win_onehot;
                        busy_q  <= 1'b1;
                        count_q <= '0;
                        limit_q <= win_limit;
                        ptr_q   <= winner;
                    end
                end
                StCount: begin
`ifdef SCHED_ABORT_EN
                    if (!bus.req[ptr_q]) begin
                        // ptr_q keeps the abandoned winner so rotation moves on.
                        state_q   <= StIdle;
                        grant_q   <= '0;
                        busy_q    <= 1'b0;
                        count_q   <= '0;
                        aborted_q <= 1'b1;
                    end else
`endif
                    if (count_q + CountOne == limit_q) begin
                        state_q <= StDone;
                        count_q <= limit_q;
                        done_q  <= grant_q;
                    end else begin
                        count_q <= count_q + CountOne;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    count_q <= '0;
                end
                default: begin
                    state_q <= StIdle;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    count_q <= '0;
                end
            endcase
        end
    end

    assign bus.grant     = grant_q;
    assign bus.busy      = busy_q;
    assign bus.count_out = count_q;
    assign bus.done      = done_q;
    assign bus.aborted   = aborted_q;
endmodule

// File: tb/tb_counter_scheduler.sv
// Directed bench for counter_scheduler (NUM_REQ=4, NUM_BITS=4).
module tb_counter_scheduler;
    logic clk;
    logic n_rst;
    int   total;
    int   passed;

    counter_scheduler_if #(.NUM_REQ(4), .NUM_BITS(4)) bus ();

    counter_scheduler #(.NUM_REQ(4), .NUM_BITS(4)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    endtask

    task automatic check1(input string tag, input logic obs, input logic expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    endtask

    task automatic set_dur(input int k, input logic [3:0] v);
        bus.duration[k*4 +: 4] = v;
    endtask

    initial begin
        logic [3:0] exp_g;
        clk          = 1'b0;
        n_rst        = 1'b0;
        total        = 0;
        passed       = 0;
        bus.req      = 4'b1111;
        bus.duration = 16'h1111;

        // Reset held for two edges with every request high.
        step();
        step();
        check4("rst_grant", bus.grant, 4'b0000);
        check4("rst_done", bus.done, 4'b0000);
        check4("rst_count", bus.count_out, 4'd0);
        check1("rst_busy", bus.busy, 1'b0);
        check1("rst_aborted", bus.aborted, 1'b0);

        // Round-robin, all durations 1: order 0,1,2,3,0.
        n_rst = 1'b1;
        for (int r = 0; r < 5; r++) begin
            exp_g = 4'b0001 << (r % 4);
            step();
            check4("rr_grant", bus.grant, exp_g);
            check4("rr_count0", bus.count_out, 4'd0);
            check1("rr_busy", bus.busy, 1'b1);
            step();
            check4("rr_done", bus.done, exp_g);
            check4("rr_count1", bus.count_out, 4'd1);
            check4("rr_grant_done", bus.grant, exp_g);
            step();
            check4("rr_idle_grant", bus.grant, 4'b0000);
            check1("rr_idle_busy", bus.busy, 1'b0);
            check4("rr_idle_done", bus.done, 4'b0000);
        end
        bus.req = 4'b0000;
        step();
        check1("quiet_busy", bus.busy, 1'b0);

        // Single request, duration 3.
        bus.req = 4'b0010;
        set_dur(1, 4'd3);
        step();
        check4("single_grant", bus.grant, 4'b0010);
        check4("single_count0", bus.count_out, 4'd0);
        for (int c = 1; c < 3; c++) begin
            step();
            check4("single_count", bus.count_out, 4'(c));
            check4("single_no_done", bus.done, 4'b0000);
            check4("single_grant_hold", bus.grant, 4'b0010);
        end
        step();
        check4("single_count3", bus.count_out, 4'd3);
        check4("single_done", bus.done, 4'b0010);
        check4("single_grant_last", bus.grant, 4'b0010);
        bus.req = 4'b0000;
        step();
        check4("single_idle_grant", bus.grant, 4'b0000);
        check4("single_idle_count", bus.count_out, 4'd0);
        check4("single_idle_done", bus.done, 4'b0000);

        // Zero duration acts as one.
        bus.req = 4'b0100;
        set_dur(2, 4'd0);
        step();
        check4("zero_grant", bus.grant, 4'b0100);
        check4("zero_count0", bus.count_out, 4'd0);
        step();
        check4("zero_count1", bus.count_out, 4'd1);
        check4("zero_done", bus.done, 4'b0100);
        bus.req = 4'b0000;
        step();
        check1("zero_idle_busy", bus.busy, 1'b0);

        // Mid-interval reset: requester 0, duration 7, reset at count 2.
        bus.req = 4'b0001;
        set_dur(0, 4'd7);
        step();
        check4("mid_grant", bus.grant, 4'b0001);
        step();
        step();
        check4("mid_count2", bus.count_out, 4'd2);
        n_rst = 1'b0;
        step();
        check4("mid_rst_grant", bus.grant, 4'b0000);
        check4("mid_rst_count", bus.count_out, 4'd0);
        check4("mid_rst_done", bus.done, 4'b0000);
        check1("mid_rst_busy", bus.busy, 1'b0);
        // Requester 1 also asks: restored pointer must still favour requester 0.
        n_rst   = 1'b1;
        bus.req = 4'b0011;
        step();
        check4("mid_regrant", bus.grant, 4'b0001);
        for (int c = 1; c < 7; c++) begin
            step();
        end
        step();
        check4("mid_done", bus.done, 4'b0001);
        check4("mid_count7", bus.count_out, 4'd7);
        bus.req = 4'b0000;
        step();
        check1("mid_idle_busy", bus.busy, 1'b0);

        // Requester 2, duration 5, drops its request at count 1.
        bus.req = 4'b0100;
        set_dur(2, 4'd5);
        step();
        check4("abort_grant", bus.grant, 4'b0100);
        step();
        check4("abort_count1", bus.count_out, 4'd1);
        bus.req = 4'b0000;
`ifdef SCHED_ABORT_EN
        step();
        check1("abort_pulse", bus.aborted, 1'b1);
        check4("abort_grant_off", bus.grant, 4'b0000);
        check1("abort_busy", bus.busy, 1'b0);
        check4("abort_count_off", bus.count_out, 4'd0);
        check4("abort_no_done", bus.done, 4'b0000);
        step();
        check1("abort_pulse_end", bus.aborted, 1'b0);
        check4("abort_still_no_done", bus.done, 4'b0000);
`else
        for (int c = 2; c < 5; c++) begin
            step();
            check4("noabort_count", bus.count_out, 4'(c));
            check1("noabort_aborted", bus.aborted, 1'b0);
        end
        step();
        check4("noabort_count5", bus.count_out, 4'd5);
        check4("noabort_done", bus.done, 4'b0100);
        step();
        check4("noabort_idle_grant", bus.grant, 4'b0000);
        check1("noabort_idle_aborted", bus.aborted, 1'b0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
